ls_station: RTL and testbench

- In-order load/store reservation station that feeds the store queue / data-memory stage.
- Accepts memory ops from dispatch and holds them with physical source tags.
- Wakes operands from CDB tag broadcasts.
- Issues the oldest entry only, in program order, once its operands are ready. The downstream stage then reads register data by tag, computes the address, and performs the load or store.

---
 rtl/lsq_pkg.sv | 19 +
 rtl/lsrs_wakeup.sv | 22 ++
 rtl/ls_station.sv | 175 +++++++++++++++++
 tb/tb_ls_station.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types and default widths for the load/store reservation station.
package lsq_pkg;

  localparam int LSQ_PTAG_W = 6;
  localparam int LSQ_ROB_W  = 4;

  typedef struct packed {
    logic                  valid;
    logic                  is_store;
    logic [LSQ_PTAG_W-1:0] p_rs;
    logic                  rs_rdy;
    logic [LSQ_PTAG_W-1:0] p_rt;
    logic                  rt_rdy;
    logic [15:0]           immed;
    logic [LSQ_ROB_W-1:0]  rob;
    logic [LSQ_PTAG_W-1:0] p_rd;
  } lsrs_entry_t;

endpackage

// File: rtl/lsrs_wakeup.sv
// Operand wakeup for one reservation-station slot (or the dispatch port):
// an operand becomes ready when it already is, or when the CDB broadcasts its tag.
module lsrs_wakeup #(
  parameter int PTAG_W = 6
) (
  input  logic              cdb_valid_i,
  input  logic [PTAG_W-1:0] cdb_tag_i,
  input  logic [PTAG_W-1:0] p_rs_i,
  input  logic              rs_rdy_i,
  input  logic [PTAG_W-1:0] p_rt_i,
  input  logic              rt_rdy_i,
  output logic              rs_rdy_o,
  output logic              rt_rdy_o
);

  // Ready bits only ever set here; clearing happens when the slot is reused.
  always_comb begin
    rs_rdy_o = rs_rdy_i | (cdb_valid_i && (cdb_tag_i == p_rs_i));
    rt_rdy_o = rt_rdy_i | (cdb_valid_i && (cdb_tag_i == p_rt_i));
  end

endmodule

// File: rtl/ls_station.sv
// In-order load/store reservation station. Only the head entry may issue.
// Optional build macro: LSRS_CDB_BYPASS_EN lets the head issue in the same
// cycle its last operand is broadcast on the CDB.
module ls_station
  import lsq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTAG_W = LSQ_PTAG_W,
  parameter int ROB_W  = LSQ_ROB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_en,
  input  logic              dispatch_is_store,
  input  logic [PTAG_W-1:0] dispatch_p_rs,
  input  logic              dispatch_rs_rdy,
  input  logic [PTAG_W-1:0] dispatch_p_rt,
  input  logic              dispatch_rt_rdy,
  input  logic [15:0]       dispatch_immed,
  input  logic [ROB_W-1:0]  dispatch_rob,
  input  logic [PTAG_W-1:0] dispatch_p_rd,
  input  logic              cdb_valid,
  input  logic [PTAG_W-1:0] cdb_tag,
  input  logic              sq_full,
  input  logic              stall_hazard,
  input  logic              recover,
  input  logic [ROB_W-1:0]  rec_rob,
  output logic              lsrs_full,
  output logic              issue,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [PTAG_W-1:0] issue_p_rs,
  output logic [PTAG_W-1:0] issue_p_rt,
  output logic [15:0]       issue_immed,
  output logic [ROB_W-1:0]  issue_rob,
  output logic [PTAG_W-1:0] issue_p_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsrs_entry_t      entries_q [DEPTH];
  lsrs_entry_t      entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             wk_rs [DEPTH];
  logic             wk_rt [DEPTH];
  logic             disp_rs_rdy, disp_rt_rdy;
  lsrs_entry_t      head_e;
  logic             head_rs_rdy, head_rt_rdy;
  logic             write;
  logic             rec_hit;
  logic [CNT_W-1:0] rec_off;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wk
    lsrs_wakeup #(.PTAG_W(PTAG_W)) u_wk (
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .p_rs_i      (entries_q[g].p_rs),
      .rs_rdy_i    (entries_q[g].rs_rdy),
      .p_rt_i      (entries_q[g].p_rt),
      .rt_rdy_i    (entries_q[g].rt_rdy),
      .rs_rdy_o    (wk_rs[g]),
      .rt_rdy_o    (wk_rt[g])
    );
  end

  // Loads have no store-data operand, so their rt is forced ready here.
  lsrs_wakeup #(.PTAG_W(PTAG_W)) u_wk_disp (
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .p_rs_i      (dispatch_p_rs),
    .rs_rdy_i    (dispatch_rs_rdy),
    .p_rt_i      (dispatch_p_rt),
    .rt_rdy_i    (dispatch_rt_rdy | ~dispatch_is_store),
    .rs_rdy_o    (disp_rs_rdy),
    .rt_rdy_o    (disp_rt_rdy)
  );

  assign head_e = entries_q[head_q];

`ifdef LSRS_CDB_BYPASS_EN
  assign head_rs_rdy = wk_rs[head_q];
  assign head_rt_rdy = wk_rt[head_q];
`else
  assign head_rs_rdy = head_e.rs_rdy;
  assign head_rt_rdy = head_e.rt_rdy;
`endif

  // Issue/dispatch handshakes and head-entry presentation.
  always_comb begin
    lsrs_full   = (count_q == CNT_W'(DEPTH));
    write       = dispatch_en && !lsrs_full && !recover && !stall_hazard;
    issue       = head_e.valid && head_rs_rdy && head_rt_rdy && !stall_hazard &&
                  !recover && !(head_e.is_store && sq_full);
    mem_wen     = issue && head_e.is_store;
    mem_ren     = issue && !head_e.is_store;
    issue_p_rs  = head_e.valid ? head_e.p_rs  : '0;
    issue_p_rt  = head_e.valid ? head_e.p_rt  : '0;
    issue_immed = head_e.valid ? head_e.immed : '0;
    issue_rob   = head_e.valid ? head_e.rob   : '0;
    issue_p_rd  = head_e.valid ? head_e.p_rd  : '0;
  end

  // Find the oldest live entry belonging to the squashed ROB range.
  always_comb begin
    rec_hit = 1'b0;
    rec_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rec_hit && (CNT_W'(i) < count_q) &&
          entries_q[PTR_W'(head_q + PTR_W'(i))].valid &&
          (entries_q[PTR_W'(head_q + PTR_W'(i))].rob == rec_rob)) begin
        rec_hit = 1'b1;
        rec_off = CNT_W'(i);
      end
    end
  end

  // Next state: wakeup everywhere, then recover truncation or pop/push.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i]        = entries_q[i];
      entries_d[i].rs_rdy = wk_rs[i];
      entries_d[i].rt_rdy = wk_rt[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (recover) begin
      if (rec_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ((CNT_W'(i) >= rec_off) && (CNT_W'(i) < count_q))
            entries_d[PTR_W'(head_q + PTR_W'(i))] = '0;
        end
        tail_d  = PTR_W'(head_q + PTR_W'(rec_off));
        count_d = rec_off;
      end
    end else begin
      if (issue) begin
        entries_d[head_q] = '0;
        head_d            = head_q + PTR_W'(1);
      end
      if (write) begin
        entries_d[tail_q] = '{valid:    1'b1,
                              is_store: dispatch_is_store,
                              p_rs:     dispatch_p_rs,
                              rs_rdy:   disp_rs_rdy,
                              p_rt:     dispatch_p_rt,
                              rt_rdy:   disp_rt_rdy,
                              immed:    dispatch_immed,
                              rob:      dispatch_rob,
                              p_rd:     dispatch_p_rd};
        tail_d            = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(write) - CNT_W'(issue);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ls_station.sv
// Directed testbench for ls_station.
module tb_ls_station;

`ifdef LSRS_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_en, dispatch_is_store, dispatch_rs_rdy, dispatch_rt_rdy;
  logic [5:0]  dispatch_p_rs, dispatch_p_rt, dispatch_p_rd;
  logic [15:0] dispatch_immed;
  logic [3:0]  dispatch_rob;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic        sq_full, stall_hazard, recover;
  logic [3:0]  rec_rob;
  logic        lsrs_full, issue, mem_wen, mem_ren;
  logic [5:0]  issue_p_rs, issue_p_rt, issue_p_rd;
  logic [15:0] issue_immed;
  logic [3:0]  issue_rob;

  int n_chk = 0;
  int n_bad = 0;

  ls_station dut (
    .clk(clk), .rst(rst),
    .dispatch_en(dispatch_en), .dispatch_is_store(dispatch_is_store),
    .dispatch_p_rs(dispatch_p_rs), .dispatch_rs_rdy(dispatch_rs_rdy),
    .dispatch_p_rt(dispatch_p_rt), .dispatch_rt_rdy(dispatch_rt_rdy),
    .dispatch_immed(dispatch_immed), .dispatch_rob(dispatch_rob),
    .dispatch_p_rd(dispatch_p_rd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .sq_full(sq_full), .stall_hazard(stall_hazard),
    .recover(recover), .rec_rob(rec_rob),
    .lsrs_full(lsrs_full), .issue(issue), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .issue_p_rs(issue_p_rs), .issue_p_rt(issue_p_rt), .issue_immed(issue_immed),
    .issue_rob(issue_rob), .issue_p_rd(issue_p_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dispatch_en = 0; dispatch_is_store = 0; dispatch_rs_rdy = 0; dispatch_rt_rdy = 0;
    dispatch_p_rs = 0; dispatch_p_rt = 0; dispatch_p_rd = 0; dispatch_immed = 0;
    dispatch_rob = 0; cdb_valid = 0; cdb_tag = 0; stall_hazard = 0;
    recover = 0; rec_rob = 0;
  endtask

  task automatic disp(input logic st, input logic [5:0] prs, input logic rsr,
                      input logic [5:0] prt, input logic rtr, input logic [15:0] imm,
                      input logic [3:0] rob, input logic [5:0] prd);
    idle();
    dispatch_en = 1; dispatch_is_store = st; dispatch_p_rs = prs; dispatch_rs_rdy = rsr;
    dispatch_p_rt = prt; dispatch_rt_rdy = rtr; dispatch_immed = imm;
    dispatch_rob = rob; dispatch_p_rd = prd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    sq_full = 0;
    rst = 1;
    #12;
    chk("rst_issue", issue, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_ren", mem_ren, 0);
    chk("rst_full", lsrs_full, 0);
    chk("rst_rob", issue_rob, 0);
    chk("rst_count", dut.count_q, 0);
    rst = 0;
    tick();

    // Load, ready at dispatch, issues the next cycle.
    disp(0, 6'd2, 1, 6'd0, 0, 16'h0004, 4'd3, 6'd10);
    #2 chk("ld_noissue_same", issue, 0);
    tick();
    idle();
    #2;
    chk("ld_issue", issue, 1);
    chk("ld_ren", mem_ren, 1);
    chk("ld_wen", mem_wen, 0);
    chk("ld_rob", issue_rob, 3);
    chk("ld_prd", issue_p_rd, 10);
    chk("ld_immed", issue_immed, 16'h0004);
    chk("ld_prs", issue_p_rs, 2);
    tick();
    #2;
    chk("ld_count0", dut.count_q, 0);
    chk("ld_idle", issue, 0);
    tick();

    // Store waiting on rt tag 7, broadcast two cycles after dispatch.
    disp(1, 6'd5, 1, 6'd7, 0, 16'h0010, 4'd5, 6'd0);
    tick();
    idle();
    #2 chk("st_wait", issue, 0);
    tick();
    cdb_valid = 1; cdb_tag = 6'd7;
    #2;
    chk("st_cdb_cycle", issue, BYP);
    chk("st_cdb_wen", mem_wen, BYP);
    tick();
    idle();
    #2;
    chk("st_after_cdb", issue, !BYP);
    chk("st_after_wen", mem_wen, !BYP);
    chk("st_after_prt", issue_p_rt, BYP ? 6'd0 : 6'd7);
    tick();
    #2 chk("st_count0", dut.count_q, 0);

    // Fill with ready stores held by sq_full; queue wraps (head starts at 2).
    for (int k = 0; k < 4; k++) begin
      disp(1, 6'(30 + k), 1, 6'(40 + k), 1, 16'(k), 4'(k + 1), 6'd0);
      sq_full = 1;
      tick();
    end
    idle();
    #2;
    chk("fill_full", lsrs_full, 1);
    chk("fill_noissue", issue, 0);
    chk("fill_head", issue_rob, 1);
    disp(1, 6'd1, 1, 6'd1, 1, 16'h0, 4'd9, 6'd0);
    tick();
    #2 chk("fill_refused", dut.count_q, 4);
    sq_full = 0;
    #2;
    chk("full_pop_issue", issue, 1);
    chk("full_pop_rob", issue_rob, 1);
    tick();
    idle();
    #2;
    chk("full_drop", lsrs_full, 0);
    chk("full_count3", dut.count_q, 3);
    for (int k = 2; k <= 4; k++) begin
      chk("fifo_issue", issue, 1);
      chk("fifo_rob", issue_rob, 32'(k));
      tick();
      #2;
    end
    chk("fifo_empty", dut.count_q, 0);
    tick();

    // Blocked store at head holds back a ready load behind it.
    disp(1, 6'd1, 1, 6'd2, 1, 16'h0, 4'd6, 6'd0);
    sq_full = 1;
    tick();
    disp(0, 6'd3, 1, 6'd0, 0, 16'h0, 4'd7, 6'd12);
    #2 chk("sq_block1", issue, 0);
    tick();
    idle();
    #2;
    chk("sq_block2", issue, 0);
    chk("sq_count2", dut.count_q, 2);
    sq_full = 0;
    #2;
    chk("sq_st_issue", mem_wen, 1);
    chk("sq_st_rob", issue_rob, 6);
    tick();
    #2;
    chk("sq_ld_issue", mem_ren, 1);
    chk("sq_ld_rob", issue_rob, 7);
    tick();

    // Recovery: rob 1..4 queued (not ready), head is slot 0 after 8 pops.
    for (int k = 0; k < 4; k++) begin
      disp(0, 6'(40 + k), 0, 6'd0, 0, 16'h0, 4'(k + 1), 6'(20 + k));
      tick();
    end
    disp(0, 6'd1, 1, 6'd0, 0, 16'h0, 4'd11, 6'd1);
    recover = 1; rec_rob = 4'd2;
    #2 chk("rec_noissue", issue, 0);
    tick();
    idle();
    #2;
    chk("rec_count", dut.count_q, 1);
    chk("rec_head", dut.head_q, 0);
    chk("rec_tail", dut.tail_q, 1);
    chk("rec_rob_left", issue_rob, 1);
    disp(0, 6'd1, 1, 6'd0, 0, 16'h0, 4'd5, 6'd33);
    tick();
    idle();
    #2;
    chk("rec_disp_count", dut.count_q, 2);
    chk("rec_disp_slot", dut.entries_q[1].rob, 5);
    recover = 1; rec_rob = 4'd12;
    tick();
    idle();
    #2 chk("rec_nomatch", dut.count_q, 2);

    // Async reset while an issue is pending.
    cdb_valid = 1; cdb_tag = 6'd40;
    tick();
    idle();
    #2 chk("pre_rst_issue", issue, 1);
    rst = 1;
    #1;
    chk("arst_issue", issue, 0);
    chk("arst_wen", mem_wen, 0);
    chk("arst_ren", mem_ren, 0);
    chk("arst_rob", issue_rob, 0);
    #1 rst = 0;
    tick();
    #2;
    chk("post_rst_count", dut.count_q, 0);
    chk("post_rst_full", lsrs_full, 0);
    disp(0, 6'd4, 1, 6'd0, 0, 16'h0008, 4'd8, 6'd9);
    tick();
    idle();
    #2;
    chk("post_rst_issue", issue, 1);
    chk("post_rst_rob", issue_rob, 8);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
